// File: rtl/axis_adxl_responder.sv
// -----------------------------------------------------------------------------
// axis_adxl_responder
//
// Emulates an ADXL345 accelerometer at the command-stream level of the I2C
// controller. Write packets update a 64x8 register file through an
// auto-incrementing pointer. Read packets are answered with register bytes
// packed four per word, little-endian by lane.
//
// Packet format: word 0 is the header with tdata[7:0] = byte count N.
// Later words carry payload bytes in lanes 0..3, qualified by tkeep.
// s_axis_tdest = {7-bit device address, R/W}, where R/W = 1 means read.
//
// Optional feature macro: ADXL_RESP_AUTOSAMPLE_EN
//   When it is defined, sample_stb/sample_x/y/z load registers 0x32..0x37
//   whenever power_ctl[3] is set. A bus write to the same register in the
//   same cycle takes priority over the sample.
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
// The master holds tdata/tkeep/tlast/tdest stable while tvalid && !tready,
// and never drops tvalid before the beat is accepted.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   s_axis_*             command stream in (tdata 32, tkeep 4, tdest 8)
//   m_axis_*             read response stream out; tdest copies the read header
//   power_ctl            live copy of register 0x2D
//   sample_*             autosample inputs (only with ADXL_RESP_AUTOSAMPLE_EN)
//   dbg_state, dbg_ptr   FSM state and register pointer, for observation
// -----------------------------------------------------------------------------
module axis_adxl_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h53,
  parameter logic [7:0] DEVID_VAL = 8'hE5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic [7:0]  s_axis_tdest,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic [7:0]  m_axis_tdest,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [7:0]  power_ctl,
`ifdef ADXL_RESP_AUTOSAMPLE_EN
  input  logic        sample_stb,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
`endif
  output logic [1:0]  dbg_state,
  output logic [5:0]  dbg_ptr
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WR_PAYLOAD = 2'd1,
    ST_RD_RESP    = 2'd2,
    ST_DRAIN      = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  regs_q [64];
  logic [7:0]  regs_d [64];
  logic [5:0]  ptr_q, ptr_d;
  logic        first_q, first_d;      // next payload byte loads the pointer
  logic        rd_pend_q, rd_pend_d;  // read header seen without tlast
  logic [5:0]  rd_addr_q, rd_addr_d;  // address of the next word to build
  logic [8:0]  rd_left_q, rd_left_d;  // bytes still to build
  logic [7:0]  snap_q [6];            // frozen copy of 0x32..0x37
  logic [7:0]  snap_d [6];
  logic [31:0] m_data_q, m_data_d;
  logic [3:0]  m_keep_q, m_keep_d;
  logic [7:0]  m_dest_q, m_dest_d;
  logic        m_last_q, m_last_d;
  logic        m_valid_q, m_valid_d;

  logic        s_accept;
  logic [8:0]  n_eff;
  logic        load_word;
  logic [5:0]  gen_addr;
  logic [8:0]  gen_left;
  logic        gen_snap;
  logic [5:0]  gen_a;
  logic [7:0]  gen_b;
  logic [31:0] gen_word;
  logic [3:0]  gen_keep;
  logic        gen_last;
  logic [5:0]  wr_ptr;
  logic        wr_first;
  logic [7:0]  wr_byte;

  assign s_axis_tready = !reset && (state_q != ST_RD_RESP);
  assign s_accept      = s_axis_tvalid && s_axis_tready;
  // A read of zero bytes still returns one byte.
  assign n_eff         = (s_axis_tdata[7:0] == 8'h00) ? 9'd1 : {1'b0, s_axis_tdata[7:0]};

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tdest  = m_dest_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign power_ctl     = regs_q[6'h2D];
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;

  // Builds one response word starting at gen_addr with gen_left bytes left.
  // The data registers come from the snapshot once a response is underway,
  // so samples landing mid-response cannot tear a multi-byte reading.
  always_comb begin
    gen_word = '0;
    gen_keep = '0;
    gen_last = (gen_left <= 9'd4);
    gen_a    = '0;
    gen_b    = '0;
    for (int i = 0; i < 4; i++) begin
      gen_a = gen_addr + 6'(i);
      gen_b = regs_q[gen_a];
      if (gen_snap && (gen_a >= 6'h32) && (gen_a <= 6'h37)) begin
        gen_b = snap_q[3'(gen_a - 6'h32)];
      end
      if (9'(i) < gen_left) begin
        gen_word[i*8 +: 8] = gen_b;
        gen_keep[i]        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rd_left_d = rd_left_q;
    snap_d    = snap_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_dest_d  = m_dest_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    load_word = 1'b0;
    gen_addr  = rd_addr_q;
    gen_left  = rd_left_q;
    gen_snap  = 1'b1;
    wr_ptr    = ptr_q;
    wr_first  = first_q;
    wr_byte   = '0;

`ifdef ADXL_RESP_AUTOSAMPLE_EN
    // Applied before the bus write below so a same-cycle bus write wins.
    if (sample_stb && regs_q[6'h2D][3]) begin
      regs_d[6'h32] = sample_x[7:0];
      regs_d[6'h33] = sample_x[15:8];
      regs_d[6'h34] = sample_y[7:0];
      regs_d[6'h35] = sample_y[15:8];
      regs_d[6'h36] = sample_z[7:0];
      regs_d[6'h37] = sample_z[15:8];
    end
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (s_accept) begin
          if (s_axis_tdest[7:1] != DEV_ADDR) begin
            if (!s_axis_tlast) state_d = ST_DRAIN;
          end else if (!s_axis_tdest[0]) begin
            // A header-only write packet changes nothing.
            if (!s_axis_tlast) begin
              state_d = ST_WR_PAYLOAD;
              first_d = 1'b1;
            end
          end else begin
            ptr_d     = ptr_q + n_eff[5:0];
            m_dest_d  = s_axis_tdest;
            snap_d[0] = regs_q[6'h32];
            snap_d[1] = regs_q[6'h33];
            snap_d[2] = regs_q[6'h34];
            snap_d[3] = regs_q[6'h35];
            snap_d[4] = regs_q[6'h36];
            snap_d[5] = regs_q[6'h37];
            // regs_q equals the snapshot being taken in this cycle.
            gen_addr  = ptr_q;
            gen_left  = n_eff;
            gen_snap  = 1'b0;
            if (s_axis_tlast) begin
              load_word = 1'b1;
              state_d   = ST_RD_RESP;
            end else begin
              rd_addr_d = ptr_q;
              rd_left_d = n_eff;
              rd_pend_d = 1'b1;
              state_d   = ST_DRAIN;
            end
          end
        end
      end

      ST_WR_PAYLOAD: begin
        if (s_accept) begin
          for (int i = 0; i < 4; i++) begin
            if (s_axis_tkeep[i]) begin
              wr_byte = s_axis_tdata[i*8 +: 8];
              if (wr_first) begin
                wr_ptr   = wr_byte[5:0];
                wr_first = 1'b0;
              end else begin
                // Register 0x00 is read-only; the pointer still advances.
                if (wr_ptr != 6'h00) regs_d[wr_ptr] = wr_byte;
                wr_ptr = wr_ptr + 6'd1;
              end
            end
          end
          ptr_d   = wr_ptr;
          first_d = wr_first;
          if (s_axis_tlast) state_d = ST_IDLE;
        end
      end

      ST_RD_RESP: begin
        if (m_valid_q && m_axis_tready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            load_word = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (s_accept && s_axis_tlast) begin
          if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            load_word = 1'b1;
            state_d   = ST_RD_RESP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load_word) begin
      m_data_d  = gen_word;
      m_keep_d  = gen_keep;
      m_last_d  = gen_last;
      m_valid_d = 1'b1;
      rd_addr_d = gen_addr + 6'd4;
      rd_left_d = gen_last ? 9'd0 : (gen_left - 9'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
      regs_q[6'h00] <= DEVID_VAL;
      regs_q[6'h2C] <= 8'h0A;
      ptr_q     <= '0;
      first_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rd_left_q <= '0;
      for (int i = 0; i < 6; i++) snap_q[i] <= 8'h00;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_dest_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rd_left_q <= rd_left_d;
      snap_q    <= snap_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_dest_q  <= m_dest_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_axis_adxl_responder.sv
module tb_axis_adxl_responder;

  localparam logic [7:0] WR_DEST = 8'hA6;
  localparam logic [7:0] RD_DEST = 8'hA7;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic [7:0]  s_axis_tdest;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic [7:0]  m_axis_tdest;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [7:0]  power_ctl;
  logic [1:0]  dbg_state;
  logic [5:0]  dbg_ptr;
`ifdef ADXL_RESP_AUTOSAMPLE_EN
  logic        sample_stb;
  logic [15:0] sample_x, sample_y, sample_z;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axis_adxl_responder dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tdest  (s_axis_tdest),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .power_ctl     (power_ctl),
`ifdef ADXL_RESP_AUTOSAMPLE_EN
    .sample_stb    (sample_stb),
    .sample_x      (sample_x),
    .sample_y      (sample_y),
    .sample_z      (sample_z),
`endif
    .dbg_state     (dbg_state),
    .dbg_ptr       (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_checks   = 0;
  int n_failures = 0;
  logic [44:0] exp_q[$];   // {tdest, tlast, tkeep, tdata}
  logic [44:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [44:0] rsp(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {RD_DEST, l, k, d};
  endfunction

  // m_axis_tready changes just after the rising edge, so at the falling
  // edge it already holds the value the next rising edge will see.
  logic rand_rdy = 1'b0;
  logic hold_rdy = 1'b1;
  initial m_axis_tready = 1'b0;
  always begin
    @(posedge clk);
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
  end

  // Monitor: records accepted response words and checks stall stability.
  logic        prev_stall = 1'b0;
  logic [44:0] prev_word;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1'b1);
        chk("stall_stable", {m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, prev_word);
      end
      if (m_axis_tvalid && m_axis_tready)
        got_q.push_back({m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                           input logic [7:0] dest, input logic last);
    int n = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tdest  = dest;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("tready_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic set_ptr(input logic [7:0] p);
    send_beat(32'd1, 4'hF, WR_DEST, 1'b0);
    send_beat({24'h0, p}, 4'h1, WR_DEST, 1'b1);
  endtask

  task automatic rd(input logic [7:0] n);
    send_beat({24'h0, n}, 4'hF, RD_DEST, 1'b1);
  endtask

  task automatic expect_resp(input string tag);
    int n = 0;
    logic [44:0] e, g;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : '1;
      chk(tag, g, e);
    end
    got_q.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

`ifdef ADXL_RESP_AUTOSAMPLE_EN
  task automatic strobe(input logic [15:0] x);
    @(negedge clk);
    sample_x   = x;
    sample_stb = 1'b1;
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tdest  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
`ifdef ADXL_RESP_AUTOSAMPLE_EN
    sample_stb = 1'b0;
    sample_x   = '0;
    sample_y   = '0;
    sample_z   = '0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_outs", {m_axis_tdata, m_axis_tkeep, m_axis_tdest, m_axis_tlast}, 45'h0);
    chk("rst_power_ctl", power_ctl, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_tready", s_axis_tready, 1'b1);
    chk("post_rst_ptr", dbg_ptr, 6'h00);

    // Write 0x08 to POWER_CTL
    send_beat(32'h2, 4'hF, WR_DEST, 1'b0);
    send_beat(32'h0000082D, 4'h3, WR_DEST, 1'b1);
    chk("pwr_ctl", power_ctl, 8'h08);
    chk("pwr_ptr", dbg_ptr, 6'h2E);
    idle_cycles(5);
    chk("wr_no_resp", got_q.size(), 0);

    // Preload 0x32..0x37 = 11..16, then read 6 bytes from 0x32
    send_beat(32'h6, 4'hF, WR_DEST, 1'b0);
    send_beat(32'h13121132, 4'hF, WR_DEST, 1'b0);
    send_beat(32'h00161514, 4'h7, WR_DEST, 1'b1);
    chk("preload_ptr", dbg_ptr, 6'h38);
    set_ptr(8'h32);
    chk("setptr_32", dbg_ptr, 6'h32);
    rd(8'h06);
    chk("rd_first_valid", m_axis_tvalid, 1'b1);
    exp_q.push_back(rsp(32'h14131211, 4'hF, 1'b0));
    exp_q.push_back(rsp(32'h00001615, 4'h3, 1'b1));
    expect_resp("rd6");
    chk("rd6_ptr", dbg_ptr, 6'h38);

    // DEVID read, then an ignored write to 0x00
    set_ptr(8'h00);
    rd(8'h01);
    exp_q.push_back(rsp(32'h000000E5, 4'h1, 1'b1));
    expect_resp("devid");
    send_beat(32'h2, 4'hF, WR_DEST, 1'b0);
    send_beat(32'h00005500, 4'h3, WR_DEST, 1'b1);
    chk("devid_wr_ptr", dbg_ptr, 6'h01);
    set_ptr(8'h00);
    rd(8'h01);
    exp_q.push_back(rsp(32'h000000E5, 4'h1, 1'b1));
    expect_resp("devid_ro");

    // Pointer wrap: write 0x3E/0x3F, write 0x01, read 4 from 0x3E
    send_beat(32'h3, 4'hF, WR_DEST, 1'b0);
    send_beat(32'h00A2A13E, 4'h7, WR_DEST, 1'b1);
    chk("wr_wrap_ptr", dbg_ptr, 6'h00);
    send_beat(32'h2, 4'hF, WR_DEST, 1'b0);
    send_beat(32'h0000B101, 4'h3, WR_DEST, 1'b1);
    set_ptr(8'h3E);
    rd(8'h04);
    exp_q.push_back(rsp(32'hB1E5A2A1, 4'hF, 1'b1));
    expect_resp("rd_wrap");
    chk("rd_wrap_ptr", dbg_ptr, 6'h02);

    // Random backpressure on an N=6 read, then a foreign packet
    set_ptr(8'h32);
    rand_rdy = 1'b1;
    rd(8'h06);
    exp_q.push_back(rsp(32'h14131211, 4'hF, 1'b0));
    exp_q.push_back(rsp(32'h00001615, 4'h3, 1'b1));
    expect_resp("rd6_bp");
    rand_rdy = 1'b0;
    send_beat(32'h2, 4'hF, 8'h3A, 1'b0);
    chk("foreign_drain", dbg_state, ST_DRAIN);
    send_beat(32'h0000FF2D, 4'h3, 8'h3A, 1'b0);
    send_beat(32'h12345678, 4'hF, 8'h3A, 1'b1);
    chk("foreign_idle", dbg_state, ST_IDLE);
    chk("foreign_pwr", power_ctl, 8'h08);
    chk("foreign_ptr", dbg_ptr, 6'h38);
    idle_cycles(5);
    chk("foreign_no_resp", got_q.size(), 0);

    // Read header without tlast: drain the trailer first, then respond
    set_ptr(8'h2C);
    send_beat(32'h2, 4'hF, RD_DEST, 1'b0);
    chk("rd_nolast_drain", dbg_state, ST_DRAIN);
    chk("rd_nolast_novalid", m_axis_tvalid, 1'b0);
    send_beat(32'h0000FF2D, 4'h3, RD_DEST, 1'b1);
    exp_q.push_back(rsp(32'h0000080A, 4'h3, 1'b1));
    expect_resp("rd_nolast");
    chk("rd_nolast_pwr", power_ctl, 8'h08);

    // N=0 reads one byte
    set_ptr(8'h2C);
    rd(8'h00);
    exp_q.push_back(rsp(32'h0000000A, 4'h1, 1'b1));
    expect_resp("rd_n0");
    chk("rd_n0_ptr", dbg_ptr, 6'h2D);

    // Header-only write and a header-only foreign read change nothing
    send_beat(32'h5, 4'hF, WR_DEST, 1'b1);
    chk("hdr_only_state", dbg_state, ST_IDLE);
    chk("hdr_only_ptr", dbg_ptr, 6'h2D);
    send_beat(32'h1, 4'hF, 8'h3B, 1'b1);
    idle_cycles(4);
    chk("foreign_rd_no_resp", got_q.size(), 0);

`ifdef ADXL_RESP_AUTOSAMPLE_EN
    // Autosample with snapshot protection during a response
    strobe(16'h0102);
    set_ptr(8'h32);
    hold_rdy = 1'b0;
    rd(8'h06);
    idle_cycles(2);
    strobe(16'h0A0B);
    hold_rdy = 1'b1;
    exp_q.push_back(rsp(32'h00000102, 4'hF, 1'b0));
    exp_q.push_back(rsp(32'h00000000, 4'h3, 1'b1));
    expect_resp("as_snap");
    set_ptr(8'h32);
    rd(8'h02);
    exp_q.push_back(rsp(32'h00000A0B, 4'h3, 1'b1));
    expect_resp("as_new");
`endif

    // Reset in the middle of a stalled response
    set_ptr(8'h32);
    hold_rdy = 1'b0;
    rd(8'h06);
    chk("mid_valid", m_axis_tvalid, 1'b1);
    idle_cycles(2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", m_axis_tvalid, 1'b0);
    chk("mid_rst_tready", s_axis_tready, 1'b0);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    hold_rdy = 1'b1;
    #1;
    chk("mid_rst_pwr", power_ctl, 8'h00);
    chk("mid_rst_ptr", dbg_ptr, 6'h00);
    set_ptr(8'h32);
    rd(8'h01);
    exp_q.push_back(rsp(32'h00000000, 4'h1, 1'b1));
    expect_resp("mid_rst_reg32");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/axis_adxl_responder.md
# axis_adxl_responder

AXI-Stream responder that emulates an ADXL345 accelerometer at the command-stream level of the I2C controller. It consumes the same write/read command packets the accelerometer requester produces and answers reads with register-file data, so requester logic can be closed-loop tested, in simulation or on hardware, without an I2C bus or physical sensor. It holds a 64×8 register file with pointer auto-increment and returns read data packed four bytes per word.

## Interface
- DEV_ADDR, 7'h53, 7-bit device address; packets match when s_axis_tdest[7:1] == DEV_ADDR, tdest[0] = 1 means read.
- DEVID_VAL, 8'hE5, read-only contents of register 0x00.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  32  command words.
- s_axis_tkeep  in  4  valid byte lanes.
- s_axis_tdest  in  8  {address, R/W}.
- s_axis_tvalid / s_axis_tlast  in  1  handshake and packet end.
- s_axis_tready  out  1  accept command word.
- m_axis_tdata  out  32  read response bytes, little-endian lanes.
- m_axis_tkeep  out  4  valid response lanes.
- m_axis_tdest  out  8  copy of the read header tdest.
- m_axis_tvalid / m_axis_tlast  out  1  response handshake and packet end.
- m_axis_tready  in  1  downstream accept.
- power_ctl  out  8  live copy of register 0x2D.
- Under ADXL_RESP_AUTOSAMPLE_EN only: sample_stb in 1; sample_x, sample_y, sample_z in 16 each.

## Operation
- Packet format: word 0 is the header, with tdata[7:0] = byte count N. Later words are payload bytes in lanes 0..3, qualified by tkeep.
- FSM states: IDLE, WR_PAYLOAD, RD_RESP, DRAIN.
- **IDLE** (tready=1), on header accept:
  - No address match: go to DRAIN if !tlast, else stay in IDLE.
  - Write: go to WR_PAYLOAD. If the header has tlast, stay in IDLE and make no changes.
  - Read: latch N (N=0 is treated as 1) and tdest, snapshot registers 0x32–0x37, then go to RD_RESP. If the read header lacks tlast, drain to tlast first, then respond.
- **WR_PAYLOAD** (tready=1):
  - Bytes are processed in lane order, kept lanes only.
  - The first payload byte of the packet loads the pointer.
  - Each later byte writes reg[ptr], then ptr = ptr+1 mod 64.
  - Writes to 0x00 are ignored, but the pointer still increments.
  - On tlast, return to IDLE. The header count N is ignored for writes.
- **RD_RESP** (s_axis_tready=0):
  - Emit ceil(N/4) words. Byte i = reg[(ptr+i) mod 64] in lane i%4.
  - Bytes 0x32–0x37 are served from the snapshot.
  - tkeep = 4'hF, except the last word: 1, 3, 7 or F for N%4 = 1, 2, 3 or 0.
  - tlast is set on the last word. The pointer advances by N. Return to IDLE after the last word is accepted.
- **DRAIN** (tready=1): discard words until tlast, then go to IDLE.
- Register reset values: 0x00 = DEVID_VAL, 0x2C = 8'h0A, all others 0. Pointer resets to 0.

## Timing
- Register write takes effect the cycle after the payload beat is accepted. A read header accepted the next cycle sees the new value.
- First response word: m_axis_tvalid asserts the cycle after the read header is accepted. Back-to-back words under continuous tready; one word per cycle.
- AXIS rules: tdata, tkeep, tlast and tdest stay stable while tvalid && !tready. tvalid never drops without acceptance.
- Reset values of outputs: s_axis_tready=0 during reset and 1 the cycle after; m_axis_tvalid=0; m_axis_tdata, tkeep, tdest, tlast = 0; power_ctl=0.
- Reset mid-packet: the packet is abandoned, any in-flight response is dropped, registers return to reset values, and the FSM goes to IDLE.

## Configuration
- ADXL_RESP_AUTOSAMPLE_EN defined:
  - On sample_stb with power_ctl[3]=1, registers 0x32–0x37 load {x,y,z} little-endian.
  - A bus write to the same register in the same cycle wins over the sample.
  - Samples arriving during RD_RESP update the registers but not the active snapshot, so no tearing.
- Not defined: the sample ports are absent, and data registers change only through bus writes.

## Test plan
- Write A6 {0x00000002, 0x0000082D keep 3 last} -> reg 0x2D=0x08, power_ctl=0x08, no m_axis output.
- Preload 0x32..0x37 = 11..16. Write A6 {1, 0x32 keep 1 last}, then read A7 {0x6 last} -> word0 0x14131211 keep F, word1 0x00001615 keep 3 tlast, tdest A7; pointer ends at 0x38.
- Read A7 {1} with ptr=0 -> single word 0x000000E5 keep 1 tlast. Then write {2, 0x5500 keep 3} -> DEVID still 0xE5.
- Pointer at 0x3E, read N=4 -> bytes reg[3E], reg[3F], reg[00], reg[01]; pointer wraps to 0x02.
- Random m_axis_tready deassertion during an N=6 read, plus a non-matching tdest 0x3A three-word packet -> outputs stable while stalled; the foreign packet is drained with no response and no register change.
- With ADXL_RESP_AUTOSAMPLE_EN, power_ctl[3]=1: strobe x=0x0102, then strobe x=0x0A0B during the response of an earlier read -> that response returns 0x0102; the next read returns 0x0A0B. Reset asserted mid-response -> tvalid=0 next cycle and reg 0x32=0.
